// File: rtl/enigma_rotor_stage_if.sv
// Substitution channel of one rotor stage: letter request in, encoded letter out.
interface enigma_rotor_stage_if #(
  parameter int unsigned W = 5
);
  logic         in_valid;
  logic [W-1:0] in_letter;
  logic         reverse;
  logic         out_valid;
  logic [W-1:0] out_letter;
  logic         in_err;

  modport master (
    output in_valid, in_letter, reverse,
    input  out_valid, out_letter, in_err
  );

  modport slave (
    input  in_valid, in_letter, reverse,
    output out_valid, out_letter, in_err
  );
endinterface

// File: rtl/enigma_rotor_stage.sv
// Clocked Enigma rotor: loadable wiring and inverse, stepping position with notch
// carry, and a one-cycle registered forward/reverse substitution.
module enigma_rotor_stage #(
  parameter int unsigned ALPHA = 26,
  parameter int unsigned W     = 5,
  parameter int unsigned NOTCH = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  enigma_rotor_stage_if.slave  sub,
  input  logic                 step_in,
  output logic                 carry_out,
  input  logic                 pos_load,
  input  logic [W-1:0]         pos_value,
  output logic [W-1:0]         pos,
  input  logic                 cfg_we,
  input  logic [W-1:0]         cfg_addr,
  input  logic [W-1:0]         cfg_data,
  output logic                 cfg_err
);

  localparam logic [W-1:0] A_W  = W'(ALPHA);
  localparam logic [W:0]   A_W1 = (W+1)'(ALPHA);

  logic [W-1:0] fwd [ALPHA];
  logic [W-1:0] inv [ALPHA];

  logic         letter_ok;
  logic [W:0]   sum;
  logic [W-1:0] idx;
  logic [W-1:0] m;
  logic [W:0]   back;
  logic [W-1:0] res;
  logic [W-1:0] pos_red;
  logic [W-1:0] pos_next;
  logic         cfg_ok;

  // Operands stay below 2*ALPHA, so each mod is one conditional subtract.
  always_comb begin
    letter_ok = (sub.in_letter != '0) && (sub.in_letter <= A_W);
    sum       = {1'b0, sub.in_letter} + {1'b0, pos} - (W+1)'(1);
    idx       = '0;
    if (letter_ok)
      idx = W'((sum >= A_W1) ? sum - A_W1 : sum);
    m    = sub.reverse ? inv[idx] : fwd[idx];
    back = {1'b0, m} + A_W1 - (W+1)'(1) - {1'b0, pos};
    res  = W'(((back >= A_W1) ? back - A_W1 : back) + (W+1)'(1));
  end

  always_comb begin
    pos_red  = (pos_value >= A_W) ? pos_value - A_W : pos_value;
    pos_next = (pos == W'(ALPHA - 1)) ? '0 : pos + W'(1);
    cfg_ok   = (cfg_addr != '0) && (cfg_addr <= A_W) &&
               (cfg_data != '0) && (cfg_data <= A_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub.out_valid  <= 1'b0;
      sub.out_letter <= '0;
      sub.in_err     <= 1'b0;
    end else begin
      sub.out_valid <= sub.in_valid;
      sub.in_err    <= sub.in_valid && !letter_ok;
      if (sub.in_valid)
        sub.out_letter <= letter_ok ? res : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (pos_load) begin
        pos <= pos_red;
      end else if (step_in) begin
        pos       <= pos_next;
        carry_out <= (pos == W'(NOTCH));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
      for (int unsigned i = 0; i < ALPHA; i++) begin
        fwd[i] <= W'(i + 1);
        inv[i] <= W'(i + 1);
      end
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        fwd[cfg_addr - W'(1)] <= cfg_data;
        inv[cfg_data - W'(1)] <= cfg_addr;
      end
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage with hand-computed expectations.
module tb_enigma_rotor_stage;
  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         step_in = 1'b0, carry_out;
  logic         pos_load = 1'b0;
  logic [W-1:0] pos_value = '0, pos;
  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_addr = '0, cfg_data = '0;
  logic         cfg_err;
  int passed = 0;
  int total  = 0;

  enigma_rotor_stage_if #(.W(W)) sub ();

  enigma_rotor_stage #(.ALPHA(26), .W(W), .NOTCH(21)) dut (
    .clk(clk), .rst(rst), .sub(sub),
    .step_in(step_in), .carry_out(carry_out),
    .pos_load(pos_load), .pos_value(pos_value), .pos(pos),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sub.in_valid = 1'b0; step_in = 1'b0; pos_load = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); sub.in_letter = '0; sub.reverse = 1'b0;
    tick(); tick();
    total++; if (pos !== 5'd0) $display("FAIL reset_pos: got %0d expected 0", pos); else passed++;
    total++; if (sub.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", sub.out_valid); else passed++;
    total++; if (sub.out_letter !== 5'd0) $display("FAIL reset_out_letter: got %0d expected 0", sub.out_letter); else passed++;
    total++; if ({sub.in_err, carry_out, cfg_err} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {sub.in_err, carry_out, cfg_err}); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    pos_load = 1'b1; pos_value = 5'd3; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd5; sub.reverse = 1'b0; tick(); idle();
    total++; if (sub.out_valid !== 1'b1) $display("FAIL ident_valid: got %b expected 1", sub.out_valid); else passed++;
    total++; if (sub.out_letter !== 5'd5) $display("FAIL ident_letter: got %0d expected 5", sub.out_letter); else passed++;
    total++; if (pos !== 5'd3) $display("FAIL ident_pos: got %0d expected 3", pos); else passed++;
    tick();
    total++; if (sub.out_valid !== 1'b0) $display("FAIL ident_pulse: got %b expected 0", sub.out_valid); else passed++;
    total++; if (sub.out_letter !== 5'd5) $display("FAIL ident_hold: got %0d expected 5", sub.out_letter); else passed++;
  endtask

  task automatic test_config();
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 5'd2; tick();
    cfg_addr = 5'd2; cfg_data = 5'd1; tick(); idle();
    total++; if (cfg_err !== 1'b0) $display("FAIL cfg_ok_err: got %b expected 0", cfg_err); else passed++;
    pos_load = 1'b1; pos_value = 5'd0; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd1; sub.reverse = 1'b0; tick(); idle();
    total++; if (sub.out_letter !== 5'd2) $display("FAIL cfg_fwd_p0: got %0d expected 2", sub.out_letter); else passed++;
    pos_load = 1'b1; pos_value = 5'd1; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd26; tick(); idle();
    total++; if (sub.out_letter !== 5'd1) $display("FAIL cfg_fwd_p1_z: got %0d expected 1", sub.out_letter); else passed++;
    pos_load = 1'b1; pos_value = 5'd0; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd2; sub.reverse = 1'b1; tick(); idle();
    total++; if (sub.out_letter !== 5'd1) $display("FAIL cfg_rev_b: got %0d expected 1", sub.out_letter); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd1; sub.reverse = 1'b1; tick(); idle();
    total++; if (sub.out_letter !== 5'd2) $display("FAIL cfg_rev_a: got %0d expected 2", sub.out_letter); else passed++;
    sub.reverse = 1'b0;
  endtask

  task automatic test_step();
    pos_load = 1'b1; pos_value = 5'd21; tick(); idle();
    step_in = 1'b1; tick(); idle();
    total++; if (pos !== 5'd22) $display("FAIL step_pos22: got %0d expected 22", pos); else passed++;
    total++; if (carry_out !== 1'b1) $display("FAIL step_carry: got %b expected 1", carry_out); else passed++;
    tick();
    total++; if (carry_out !== 1'b0) $display("FAIL step_carry_pulse: got %b expected 0", carry_out); else passed++;
    pos_load = 1'b1; pos_value = 5'd25; tick(); idle();
    step_in = 1'b1; tick(); idle();
    total++; if (pos !== 5'd0) $display("FAIL step_wrap: got %0d expected 0", pos); else passed++;
    total++; if (carry_out !== 1'b0) $display("FAIL step_wrap_carry: got %b expected 0", carry_out); else passed++;
    pos_load = 1'b1; pos_value = 5'd21; tick(); idle();
    pos_load = 1'b1; pos_value = 5'd5; step_in = 1'b1; tick(); idle();
    total++; if (pos !== 5'd5) $display("FAIL load_priority: got %0d expected 5", pos); else passed++;
    total++; if (carry_out !== 1'b0) $display("FAIL load_no_carry: got %b expected 0", carry_out); else passed++;
    pos_load = 1'b1; pos_value = 5'd30; tick(); idle();
    total++; if (pos !== 5'd4) $display("FAIL load_mod: got %0d expected 4", pos); else passed++;
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    sub.in_valid = 1'b1; sub.in_letter = 5'd5; sub.reverse = 1'b0;
    step_in = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd5; cfg_data = 5'd9; tick(); idle();
    total++; if (sub.out_letter !== 5'd5) $display("FAIL simul_old_state: got %0d expected 5", sub.out_letter); else passed++;
    total++; if (pos !== 5'd1) $display("FAIL simul_pos: got %0d expected 1", pos); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd4; tick(); idle();
    total++; if (sub.out_letter !== 5'd8) $display("FAIL simul_new_table: got %0d expected 8", sub.out_letter); else passed++;
  endtask

  task automatic test_errors();
    pos_load = 1'b1; pos_value = 5'd0; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd0; tick(); idle();
    total++; if ({sub.out_valid, sub.in_err, sub.out_letter} !== {2'b11, 5'd0}) $display("FAIL err_zero: got v%b e%b %0d expected v1 e1 0", sub.out_valid, sub.in_err, sub.out_letter); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd27; sub.reverse = 1'b1; tick(); idle();
    total++; if ({sub.out_valid, sub.in_err, sub.out_letter} !== {2'b11, 5'd0}) $display("FAIL err_27: got v%b e%b %0d expected v1 e1 0", sub.out_valid, sub.in_err, sub.out_letter); else passed++;
    sub.reverse = 1'b0;
    tick();
    total++; if (sub.in_err !== 1'b0) $display("FAIL err_pulse: got %b expected 0", sub.in_err); else passed++;
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_data = 5'd27; tick(); idle();
    total++; if (cfg_err !== 1'b1) $display("FAIL cfg_err: got %b expected 1", cfg_err); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd3; tick(); idle();
    total++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_pulse: got %b expected 0", cfg_err); else passed++;
    total++; if (sub.out_letter !== 5'd3) $display("FAIL cfg_err_unchanged: got %0d expected 3", sub.out_letter); else passed++;
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 5'd4; tick(); idle();
    total++; if (cfg_err !== 1'b1) $display("FAIL cfg_err_addr0: got %b expected 1", cfg_err); else passed++;
  endtask

  task automatic test_reset_midflight();
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = 5'd7; tick(); idle();
    pos_load = 1'b1; pos_value = 5'd4; tick(); idle();
    sub.in_valid = 1'b1; sub.in_letter = 5'd1; sub.reverse = 1'b0;
    #3 rst = 1'b1;
    #1 idle();
    total++; if (pos !== 5'd0) $display("FAIL mid_async_pos: got %0d expected 0", pos); else passed++;
    tick();
    total++; if (sub.out_valid !== 1'b0) $display("FAIL mid_no_valid: got %b expected 0", sub.out_valid); else passed++;
    rst = 1'b0; tick();
    total++; if (sub.out_valid !== 1'b0) $display("FAIL mid_no_valid_after: got %b expected 0", sub.out_valid); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd1; tick(); idle();
    total++; if (sub.out_letter !== 5'd1) $display("FAIL mid_identity_fwd: got %0d expected 1", sub.out_letter); else passed++;
    sub.in_valid = 1'b1; sub.in_letter = 5'd7; sub.reverse = 1'b1; tick(); idle();
    total++; if (sub.out_letter !== 5'd7) $display("FAIL mid_identity_rev: got %0d expected 7", sub.out_letter); else passed++;
  endtask

  initial begin
    sub.in_valid = 1'b0; sub.in_letter = '0; sub.reverse = 1'b0;
    test_reset();
    test_identity();
    test_config();
    test_step();
    test_simultaneous();
    test_errors();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/enigma_rotor_stage.md
Name: enigma_rotor_stage

Overview:
- Parametrised, clocked successor to the fixed combinational rotors.
- Holds a runtime-loadable wiring permutation and its inverse, a rotor position register with stepping, and a notch carry.
- Performs registered forward or reverse substitution with a valid handshake.
- Rotor stages are chained (carry_out feeds the next stage's step_in) between the keyboard controller and the reflector.

Parameters:
- ALPHA, 26, alphabet size; letters are encoded 1..ALPHA, and 0 is invalid.
- W, 5, letter/position width; must satisfy 2^W > ALPHA.
- NOTCH, 21, 0-based position at which a step produces carry_out (rotor III turnover).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a letter is presented on in_letter this cycle.
- in_letter  input  W  letter to encode, 1..ALPHA.
- reverse  input  1  0 = forward table (entry path), 1 = inverse table (return path); sampled with in_valid.
- out_valid  output  1  out_letter valid, one-cycle pulse.
- out_letter  output  W  encoded letter 1..ALPHA, or 0 on error.
- in_err  output  1  one-cycle pulse alongside out_valid when in_letter was out of range.
- step_in  input  1  advance position by one.
- carry_out  output  1  one-cycle pulse when a step leaves position NOTCH.
- pos_load  input  1  load pos_value into position.
- pos_value  input  W  0-based position, 0..ALPHA-1.
- pos  output  W  current 0-based position.
- cfg_we  input  1  wiring write strobe.
- cfg_addr  input  W  source letter 1..ALPHA.
- cfg_data  input  W  destination letter 1..ALPHA.
- cfg_err  output  1  one-cycle pulse when a write was rejected.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - pos=0; fwd[i]=inv[i]=i+1 (identity wiring).
  - out_valid=0, out_letter=0, in_err=0, carry_out=0, cfg_err=0.
  - Reset mid-transaction discards the in-flight result; no out_valid follows.
- Substitution:
  - Latency is exactly 1 cycle: in_valid in cycle N gives out_valid in cycle N+1. Back-to-back every cycle; no backpressure.
  - idx = (in_letter-1+pos) mod ALPHA.
  - m = fwd[idx] when reverse=0, inv[idx] when reverse=1.
  - out_letter = ((m-1-pos+ALPHA) mod ALPHA)+1.
  - Intermediates use W+1 bits; mod is a single conditional subtract of ALPHA, since operands are < 2*ALPHA. No divider.
  - If in_letter is 0 or >ALPHA: out_letter=0 and in_err=1 with out_valid.
  - out_letter holds its last value when out_valid=0.
- Position:
  - pos_load has priority over step_in.
  - A step sets pos to pos+1, wrapping ALPHA-1 to 0.
  - carry_out=1 in the cycle after a step taken while pos==NOTCH.
  - pos_load never generates carry. pos_value >= ALPHA is reduced mod ALPHA.
- Simultaneous events:
  - in_valid with step_in or pos_load in the same cycle: the lookup uses the pre-update pos. The controller issues step one cycle before the letter.
  - in_valid with cfg_we: the lookup uses the pre-write tables.
- Config:
  - An accepted write sets fwd[cfg_addr-1]=cfg_data and inv[cfg_data-1]=cfg_addr in one cycle.
  - cfg_addr or cfg_data equal to 0 or >ALPHA: tables unchanged, cfg_err pulses next cycle.
  - Permutation integrity is the writer's responsibility. inv is only consistent after a full bijective load.
- Tables are flops or distributed RAM with combinational read and synchronous write. No block-RAM read latency is allowed.

Test Plan:
- Reset, then identity wiring, pos_load 3, in_letter=5 forward -> out_letter=5 one cycle later with out_valid=1; pos=3.
- cfg write (1->2) and (2->1); pos=0, in=1 fwd -> 2; pos_load 1, in=26 fwd -> 1; reverse, pos=0, in=2 -> 1.
- pos_load 21, step_in pulse -> pos=22, carry_out=1 for one cycle. Step at pos 25 -> pos=0, carry_out=0.
- Same cycle: in_valid in=5 (identity), step_in and cfg_we -> result uses old pos and tables; pos increments; the write is visible on the next lookup.
- in_letter=0 and in_letter=27 -> out_letter=0, in_err=1. cfg_data=27 -> cfg_err=1, tables unchanged.
- Assert rst asynchronously between in_valid and its result cycle -> out_valid stays 0, pos=0, wiring back to identity.
